// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hazard_ctrl_if : pipeline hazard-status inputs and stall/flush controls
//                  exchanged between the pipeline datapath and hazard_ctrl.
// Revision: 1.0
// ---------------------------------------------------------------------------
interface hazard_ctrl_if #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
);
   logic [REG_AW-1:0] src1_addrID;
   logic [REG_AW-1:0] src2_addrID;
   logic              src2_useID;
   logic              mem_readEX;
   logic              reg_writeEX;
   logic [REG_AW-1:0] reg_waddrEX;
   logic              mdu_opEX;
   logic              mdu_done;
   logic              branch_takenEX;
   logic              cnt_clr;

   logic              pc_stall;
   logic              ifid_stall;
   logic              idex_stall;
   logic              idex_bubble;
   logic              exmem_bubble;
   logic              ifid_flush;
   logic              mdu_start;
   logic              mdu_timeout;
   logic [CNT_W-1:0]  stall_cnt;

   modport master (
      output src1_addrID, src2_addrID, src2_useID, mem_readEX, reg_writeEX,
             reg_waddrEX, mdu_opEX, mdu_done, branch_takenEX, cnt_clr,
      input  pc_stall, ifid_stall, idex_stall, idex_bubble, exmem_bubble,
             ifid_flush, mdu_start, mdu_timeout, stall_cnt
   );

   modport slave (
      input  src1_addrID, src2_addrID, src2_useID, mem_readEX, reg_writeEX,
             reg_waddrEX, mdu_opEX, mdu_done, branch_takenEX, cnt_clr,
      output pc_stall, ifid_stall, idex_stall, idex_bubble, exmem_bubble,
             ifid_flush, mdu_start, mdu_timeout, stall_cnt
   );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hazard_ctrl : load-use / MDU / taken-branch pipeline sequencing with an
//               MDU watchdog and a saturating stall-cycle counter.
// Revision: 1.0
// ---------------------------------------------------------------------------
module hazard_ctrl #(
   parameter int REG_AW      = 5,
   parameter int MDU_TIMEOUT = 64,
   parameter int CNT_W       = 16
) (
   input  wire logic     clk,
   input  wire logic     rst,
   hazard_ctrl_if.slave  bus
);
   localparam int                c_WD_W    = $clog2(MDU_TIMEOUT);
   localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(MDU_TIMEOUT - 1);

   typedef enum logic [0:0] {
      S_RUN     = 1'b0,
      S_MD_BUSY = 1'b1
   } state_t;

   state_t            r_state;
   logic [c_WD_W-1:0] r_wd;
   logic              r_mdu_timeout;
   logic [CNT_W-1:0]  r_stall_cnt;

   logic w_load_use;
   logic w_wd_expire;
   logic w_pc_stall;
   logic w_ifid_stall;
   logic w_idex_stall;
   logic w_idex_bubble;
   logic w_exmem_bubble;
   logic w_ifid_flush;
   logic w_mdu_start;

   // Register 0 is hardwired, so a load targeting it never creates a dependency.
   assign w_load_use = bus.mem_readEX && bus.reg_writeEX &&
                       (bus.reg_waddrEX != {REG_AW{1'b0}}) &&
                       ((bus.src1_addrID == bus.reg_waddrEX) ||
                        (bus.src2_useID && (bus.src2_addrID == bus.reg_waddrEX)));

   assign w_wd_expire = (r_state == S_MD_BUSY) && !bus.mdu_done && (r_wd == c_WD_LAST);

   always_comb begin
      w_pc_stall     = 1'b0;
      w_ifid_stall   = 1'b0;
      w_idex_stall   = 1'b0;
      w_idex_bubble  = 1'b0;
      w_exmem_bubble = 1'b0;
      w_ifid_flush   = 1'b0;
      w_mdu_start    = 1'b0;
      if (!rst) begin
         unique case (r_state)
            S_RUN: begin
               if (bus.mdu_opEX) begin
                  w_mdu_start    = 1'b1;
                  w_pc_stall     = 1'b1;
                  w_ifid_stall   = 1'b1;
                  w_idex_stall   = 1'b1;
                  w_exmem_bubble = 1'b1;
               end else if (bus.branch_takenEX) begin
                  w_ifid_flush  = 1'b1;
                  w_idex_bubble = 1'b1;
               end else if (w_load_use) begin
                  w_pc_stall    = 1'b1;
                  w_ifid_stall  = 1'b1;
                  w_idex_bubble = 1'b1;
               end
            end
            S_MD_BUSY: begin
               // On the done cycle everything releases so EX advances at this edge.
               if (!bus.mdu_done) begin
                  w_pc_stall     = 1'b1;
                  w_ifid_stall   = 1'b1;
                  w_idex_stall   = 1'b1;
                  w_exmem_bubble = 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_RUN;
         r_wd          <= '0;
         r_mdu_timeout <= 1'b0;
         r_stall_cnt   <= '0;
      end else begin
         unique case (r_state)
            S_RUN: begin
               if (bus.mdu_opEX) begin
                  r_state <= S_MD_BUSY;
                  r_wd    <= '0;
               end
            end
            S_MD_BUSY: begin
               if (bus.mdu_done) begin
                  r_state <= S_RUN;
               end else if (w_wd_expire) begin
                  r_state       <= S_RUN;
                  r_mdu_timeout <= 1'b1;
               end else begin
                  r_wd <= r_wd + c_WD_W'(1);
               end
            end
         endcase

         if (bus.cnt_clr) begin
            r_stall_cnt <= '0;
         end else if (w_pc_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end
      end
   end

   assign bus.pc_stall     = w_pc_stall;
   assign bus.ifid_stall   = w_ifid_stall;
   assign bus.idex_stall   = w_idex_stall;
   assign bus.idex_bubble  = w_idex_bubble;
   assign bus.exmem_bubble = w_exmem_bubble;
   assign bus.ifid_flush   = w_ifid_flush;
   assign bus.mdu_start    = w_mdu_start;
   assign bus.mdu_timeout  = r_mdu_timeout;
   assign bus.stall_cnt    = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_hazard_ctrl : directed hazard scenarios plus randomized traffic checked
//                  every cycle against a behavioural pipeline-control model.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;
   localparam int REG_AW      = 5;
   localparam int MDU_TIMEOUT = 8;
   localparam int CNT_W       = 4;
   localparam int CNT_MAX     = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_pass   = 0;

   // Model: is the MDU occupying EX, how many stalled busy cycles so far, flag, counter.
   bit   m_busy;
   int   m_busy_cycles;
   bit   m_tmo;
   int   m_cnt;

   hazard_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) hif ();

   hazard_ctrl #(
      .REG_AW      (REG_AW),
      .MDU_TIMEOUT (MDU_TIMEOUT),
      .CNT_W       (CNT_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (hif)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] dut_ctl();
      return {hif.pc_stall, hif.ifid_stall, hif.idex_stall, hif.idex_bubble,
              hif.exmem_bubble, hif.ifid_flush, hif.mdu_start};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   function automatic bit id_reads(input logic [REG_AW-1:0] r);
      return (hif.src1_addrID == r) || (hif.src2_useID && hif.src2_addrID == r);
   endfunction

   // Expected controls, bit order {pc, ifid, idex_stall, idex_bubble, exmem_bubble, flush, start}.
   function automatic logic [6:0] model_ctl();
      bit lu;
      lu = hif.mem_readEX && hif.reg_writeEX && (hif.reg_waddrEX != 0) && id_reads(hif.reg_waddrEX);
      if (rst) return 7'b0;
      if (m_busy) return hif.mdu_done ? 7'b0 : 7'b1110100;
      if (hif.mdu_opEX) return 7'b1110101;
      if (hif.branch_takenEX) return 7'b0001010;
      if (lu) return 7'b1101000;
      return 7'b0;
   endfunction

   task automatic eval_cycle();
      logic [6:0] exp;
      #1;
      exp = model_ctl();
      chk("controls", {25'b0, dut_ctl()}, {25'b0, exp});
      chk("mdu_timeout", {31'b0, hif.mdu_timeout}, {31'b0, m_tmo});
      chk("stall_cnt", {{(32-CNT_W){1'b0}}, hif.stall_cnt}, m_cnt);
      if (rst) begin
         m_busy = 0; m_busy_cycles = 0; m_tmo = 0; m_cnt = 0;
      end else begin
         if (hif.cnt_clr) m_cnt = 0;
         else if (exp[6] && m_cnt < CNT_MAX) m_cnt++;
         if (!m_busy) begin
            if (hif.mdu_opEX) begin m_busy = 1; m_busy_cycles = 0; end
         end else if (hif.mdu_done) begin
            m_busy = 0;
         end else begin
            m_busy_cycles++;
            if (m_busy_cycles == MDU_TIMEOUT) begin m_busy = 0; m_tmo = 1; end
         end
      end
   endtask

   task automatic advance();
      @(negedge clk);
   endtask

   task automatic idle();
      hif.src1_addrID = '0; hif.src2_addrID = '0; hif.src2_useID = 1'b0;
      hif.mem_readEX = 1'b0; hif.reg_writeEX = 1'b0; hif.reg_waddrEX = '0;
      hif.mdu_opEX = 1'b0; hif.mdu_done = 1'b0; hif.branch_takenEX = 1'b0;
      hif.cnt_clr = 1'b0;
   endtask

   task automatic set_load(input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] s1,
                           input logic [REG_AW-1:0] s2, input logic s2use);
      hif.mem_readEX = 1'b1; hif.reg_writeEX = 1'b1; hif.reg_waddrEX = rd;
      hif.src1_addrID = s1; hif.src2_addrID = s2; hif.src2_useID = s2use;
   endtask

   initial begin
      m_busy = 0; m_busy_cycles = 0; m_tmo = 0; m_cnt = 0;
      rst = 1'b1;
      idle();
      advance();

      // Reset dominates even with an MDU op and a load-use hazard presented.
      hif.mdu_opEX = 1'b1; set_load(5, 5, 0, 1'b0);
      eval_cycle(); chk("reset_ctl_zero", {25'b0, dut_ctl()}, 32'h0); advance();
      rst = 1'b0; idle();
      eval_cycle(); chk("reset_cnt_zero", {28'b0, hif.stall_cnt}, 32'd0); advance();

      // Load-use on src1.
      set_load(5, 5, 9, 1'b1);
      eval_cycle(); chk("lu_stall_bubble",
                        {28'b0, hif.pc_stall, hif.ifid_stall, hif.idex_bubble, hif.idex_stall},
                        32'b1110);
      advance(); idle();
      eval_cycle(); chk("lu_cnt_one", {28'b0, hif.stall_cnt}, 32'd1); advance();

      // r0 destination and an unused src2 never stall.
      set_load(0, 0, 0, 1'b1);
      eval_cycle(); chk("r0_no_stall", {31'b0, hif.pc_stall}, 32'd0); advance();
      set_load(7, 3, 7, 1'b0);
      eval_cycle(); chk("src2_unused_no_stall", {31'b0, hif.pc_stall}, 32'd0); advance();

      // MDU op, done on the fifth busy-state cycle.
      idle(); hif.mdu_opEX = 1'b1;
      eval_cycle(); chk("mdu_start_pulse", {31'b0, hif.mdu_start}, 32'd1); advance();
      for (int i = 1; i <= 4; i++) begin
         eval_cycle();
         if (i == 1) chk("mdu_busy_no_start", {30'b0, hif.mdu_start, hif.pc_stall}, 32'b01);
         advance();
      end
      hif.mdu_done = 1'b1;
      eval_cycle(); chk("mdu_done_release", {25'b0, dut_ctl()}, 32'h0); advance();
      idle();
      eval_cycle(); chk("mdu_cnt_six", {28'b0, hif.stall_cnt}, 32'd6); advance();

      // MDU beats a simultaneous taken branch.
      hif.mdu_opEX = 1'b1; hif.branch_takenEX = 1'b1;
      eval_cycle(); chk("mdu_over_branch", {30'b0, hif.ifid_flush, hif.mdu_start}, 32'b01); advance();
      hif.branch_takenEX = 1'b0; hif.mdu_done = 1'b1;
      eval_cycle(); advance(); idle();

      // Watchdog: eight busy cycles with no done.
      hif.mdu_opEX = 1'b1;
      eval_cycle(); advance();
      for (int i = 0; i < MDU_TIMEOUT; i++) begin
         eval_cycle();
         if (i == MDU_TIMEOUT - 1)
            chk("wd_last_busy", {30'b0, hif.pc_stall, hif.mdu_timeout}, 32'b10);
         advance();
      end
      idle();
      eval_cycle(); chk("wd_fired", {30'b0, hif.pc_stall, hif.mdu_timeout}, 32'b01); advance();
      eval_cycle(); eval_cycle_dummy_guard(); advance();
      chk("cnt_saturated", {28'b0, hif.stall_cnt}, CNT_MAX);

      // Clear wins over a concurrent stall.
      set_load(4, 1, 4, 1'b1); hif.cnt_clr = 1'b1;
      eval_cycle(); advance(); idle();
      eval_cycle(); chk("cnt_clr_wins", {28'b0, hif.stall_cnt}, 32'd0); advance();

      // Reset in the middle of an MDU wait.
      hif.mdu_opEX = 1'b1;
      eval_cycle(); advance(); eval_cycle(); advance(); eval_cycle(); advance();
      rst = 1'b1;
      eval_cycle(); chk("rst_mid_busy_ctl", {25'b0, dut_ctl()}, 32'h0); advance();
      rst = 1'b0; idle();
      eval_cycle(); chk("rst_cleared_flag", {30'b0, hif.pc_stall, hif.mdu_timeout}, 32'b00); advance();
      hif.mdu_opEX = 1'b1;
      eval_cycle(); chk("restart_after_rst", {31'b0, hif.mdu_start}, 32'd1); advance();
      hif.mdu_done = 1'b1;
      eval_cycle(); advance(); idle();

      // Randomized traffic; small address range makes dependencies frequent.
      for (int n = 0; n < 3000; n++) begin
         rst                = ($urandom_range(0, 99) == 0);
         hif.src1_addrID    = REG_AW'($urandom_range(0, 3));
         hif.src2_addrID    = REG_AW'($urandom_range(0, 3));
         hif.src2_useID     = 1'($urandom_range(0, 1));
         hif.mem_readEX     = ($urandom_range(0, 2) != 0);
         hif.reg_writeEX    = ($urandom_range(0, 3) != 0);
         hif.reg_waddrEX    = REG_AW'($urandom_range(0, 3));
         hif.mdu_opEX       = ($urandom_range(0, 5) == 0);
         hif.mdu_done       = ($urandom_range(0, 3) == 0);
         hif.branch_takenEX = ($urandom_range(0, 4) == 0);
         hif.cnt_clr        = ($urandom_range(0, 29) == 0);
         eval_cycle();
         advance();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Keeps the flag-hold check on a plain idle cycle after the watchdog fired.
   task automatic eval_cycle_dummy_guard();
      chk("wd_flag_held", {31'b0, hif.mdu_timeout}, 32'd1);
   endtask

endmodule
`default_nettype wire
